// File: rtl/reg_file_wb_if.sv
// Bus bundle for reg_file_wb: three read ports, one write request port,
// pipeline control inputs and write-back status outputs.
interface reg_file_wb_if;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [1:0] rd_addr_0;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       stall;
  logic       flush;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [7:0] rd_data_0;
  logic       wb_pending;
  logic       wr_dropped;

  modport master (
    output rd_addr_a, rd_addr_b, rd_addr_0, wr_en, wr_addr, wr_data, stall, flush,
    input  rd_data_a, rd_data_b, rd_data_0, wb_pending, wr_dropped
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, rd_addr_0, wr_en, wr_addr, wr_data, stall, flush,
    output rd_data_a, rd_data_b, rd_data_0, wb_pending, wr_dropped
  );
endinterface

// File: rtl/reg_file_wb.sv
// 4x8 register file with a one-entry write-back stage in front of the array.
// Reads are combinational and bypass the pending write-back entry.
module reg_file_wb (
  input  logic          clk,
  input  logic          reset,
  reg_file_wb_if.slave  bus
);

  logic [7:0] mem [4];
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       wr_dropped_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      wr_dropped_q <= 1'b0;
    end else begin
      // Commit ignores stall; flush squashes the entry instead of writing it.
      if (wb_valid && !bus.flush) mem[wb_addr] <= wb_data;
      wr_dropped_q <= bus.wr_en && bus.stall;
      if (bus.wr_en && !bus.stall) begin
        wb_valid <= 1'b1;
        wb_addr  <= bus.wr_addr;
        wb_data  <= bus.wr_data;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rd_data_a = (wb_valid && bus.rd_addr_a == wb_addr) ? wb_data : mem[bus.rd_addr_a];
    bus.rd_data_b = (wb_valid && bus.rd_addr_b == wb_addr) ? wb_data : mem[bus.rd_addr_b];
    bus.rd_data_0 = (wb_valid && bus.rd_addr_0 == wb_addr) ? wb_data : mem[bus.rd_addr_0];
    bus.wb_pending = wb_valid;
    bus.wr_dropped = wr_dropped_q;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized
// traffic compared against a queue-based model of in-flight writes.
module tb_reg_file_wb;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  reg_file_wb_if bus ();
  reg_file_wb dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: architectural array plus ordered list of captured, uncommitted writes.
  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  logic [7:0] m_mem [4];
  wr_t        m_pend [$];
  logic       m_drop;

  function automatic logic [7:0] model_read(input logic [1:0] addr);
    for (int i = m_pend.size() - 1; i >= 0; i--)
      if (m_pend[i].a == addr) return m_pend[i].d;
    return m_mem[addr];
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
      m_pend.delete();
      m_drop = 1'b0;
    end else begin
      if (m_pend.size() > 0) begin
        if (!bus.flush) m_mem[m_pend[0].a] = m_pend[0].d;
        void'(m_pend.pop_front());
      end
      m_drop = bus.wr_en && bus.stall;
      if (bus.wr_en && !bus.stall) m_pend.push_back('{bus.wr_addr, bus.wr_data});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr_a = 2'(a); bus.rd_addr_b = 2'(a); bus.rd_addr_0 = 2'(a); #1;
      checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL reset_rd_a[%0d]: got %h want 00", a, bus.rd_data_a); end
      checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL reset_rd_b[%0d]: got %h want 00", a, bus.rd_data_b); end
      checks++; if (bus.rd_data_0 !== 8'h00) begin errors++; $display("FAIL reset_rd_0[%0d]: got %h want 00", a, bus.rd_data_0); end
    end
    checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", bus.wb_pending); end
    checks++; if (bus.wr_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", bus.wr_dropped); end
  endtask

  task automatic test_basic_write();
    do_reset();
    bus.rd_addr_a = 2'd2;
    wr(2'd2, 8'h5A);
    tick(); idle_inputs();
    checks++; if (bus.rd_data_a !== 8'h5A) begin errors++; $display("FAIL basic_bypass: got %h want 5a", bus.rd_data_a); end
    checks++; if (bus.wb_pending !== 1'b1) begin errors++; $display("FAIL basic_pending1: got %b want 1", bus.wb_pending); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.rd_data_a !== 8'h5A) begin errors++; $display("FAIL basic_array[%0d]: got %h want 5a", c, bus.rd_data_a); end
      checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL basic_pending0[%0d]: got %b want 0", c, bus.wb_pending); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rd_addr_b = 2'd1;
    wr(2'd1, 8'h11); tick();
    checks++; if (bus.rd_data_b !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h want 11", bus.rd_data_b); end
    wr(2'd1, 8'h22); tick(); idle_inputs();
    checks++; if (bus.rd_data_b !== 8'h22) begin errors++; $display("FAIL b2b_second: got %h want 22", bus.rd_data_b); end
    checks++; if (bus.wb_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b want 1", bus.wb_pending); end
    tick(); tick();
    checks++; if (bus.rd_data_b !== 8'h22) begin errors++; $display("FAIL b2b_final: got %h want 22", bus.rd_data_b); end
    checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.wb_pending); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.rd_addr_0 = 2'd3;
    wr(2'd3, 8'h33); tick(); idle_inputs();
    checks++; if (bus.rd_data_0 !== 8'h33) begin errors++; $display("FAIL flush_bypass: got %h want 33", bus.rd_data_0); end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL flush_pending: got %b want 0", bus.wb_pending); end
    checks++; if (bus.rd_data_0 !== 8'h00) begin errors++; $display("FAIL flush_squash: got %h want 00", bus.rd_data_0); end
    tick();
    checks++; if (bus.rd_data_0 !== 8'h00) begin errors++; $display("FAIL flush_nocommit: got %h want 00", bus.rd_data_0); end
    bus.rd_addr_a = 2'd0; bus.rd_addr_b = 2'd2;
    wr(2'd2, 8'h55); tick();
    wr(2'd0, 8'h44); bus.flush = 1'b1; tick(); idle_inputs();
    checks++; if (bus.wb_pending !== 1'b1) begin errors++; $display("FAIL flushwr_pending: got %b want 1", bus.wb_pending); end
    checks++; if (bus.rd_data_a !== 8'h44) begin errors++; $display("FAIL flushwr_new: got %h want 44", bus.rd_data_a); end
    checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL flushwr_old: got %h want 00", bus.rd_data_b); end
    tick();
    checks++; if (bus.rd_data_a !== 8'h44) begin errors++; $display("FAIL flushwr_commit: got %h want 44", bus.rd_data_a); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.rd_addr_a = 2'd0; bus.rd_addr_b = 2'd1; bus.rd_addr_0 = 2'd2;
    wr(2'd0, 8'hAA); bus.stall = 1'b1; tick(); idle_inputs();
    checks++; if (bus.wr_dropped !== 1'b1) begin errors++; $display("FAIL stall_dropped: got %b want 1", bus.wr_dropped); end
    checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL stall_nocapture: got %b want 0", bus.wb_pending); end
    checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL stall_data: got %h want 00", bus.rd_data_a); end
    tick();
    checks++; if (bus.wr_dropped !== 1'b0) begin errors++; $display("FAIL stall_pulse: got %b want 0", bus.wr_dropped); end
    checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL stall_data2: got %h want 00", bus.rd_data_a); end
    wr(2'd1, 8'h66); tick();
    wr(2'd2, 8'h99); bus.stall = 1'b1; tick(); idle_inputs();
    checks++; if (bus.rd_data_b !== 8'h66) begin errors++; $display("FAIL stall_commit: got %h want 66", bus.rd_data_b); end
    checks++; if (bus.rd_data_0 !== 8'h00) begin errors++; $display("FAIL stall_lost: got %h want 00", bus.rd_data_0); end
    checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL stall_pending: got %b want 0", bus.wb_pending); end
    checks++; if (bus.wr_dropped !== 1'b1) begin errors++; $display("FAIL stall_dropped2: got %b want 1", bus.wr_dropped); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rd_addr_a = 2'd2; bus.rd_addr_b = 2'd2; bus.rd_addr_0 = 2'd2;
    wr(2'd2, 8'h77); tick(); idle_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (bus.wb_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", bus.wb_pending); end
    tick();
    checks++; if (bus.rd_data_a !== 8'h00) begin errors++; $display("FAIL rstmid_a: got %h want 00", bus.rd_data_a); end
    checks++; if (bus.rd_data_b !== 8'h00) begin errors++; $display("FAIL rstmid_b: got %h want 00", bus.rd_data_b); end
    checks++; if (bus.rd_data_0 !== 8'h00) begin errors++; $display("FAIL rstmid_0: got %h want 00", bus.rd_data_0); end
  endtask

  task automatic test_multi_bypass();
    do_reset();
    bus.rd_addr_a = 2'd1; bus.rd_addr_b = 2'd1; bus.rd_addr_0 = 2'd1;
    wr(2'd1, 8'hC3); tick(); idle_inputs();
    checks++; if (bus.rd_data_a !== 8'hC3) begin errors++; $display("FAIL mbyp_a: got %h want c3", bus.rd_data_a); end
    checks++; if (bus.rd_data_b !== 8'hC3) begin errors++; $display("FAIL mbyp_b: got %h want c3", bus.rd_data_b); end
    checks++; if (bus.rd_data_0 !== 8'hC3) begin errors++; $display("FAIL mbyp_0: got %h want c3", bus.rd_data_0); end
    checks++; if (bus.wb_pending !== 1'b1) begin errors++; $display("FAIL mbyp_pending: got %b want 1", bus.wb_pending); end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      bus.wr_en     = ($urandom_range(0, 3) != 0);
      bus.wr_addr   = 2'($urandom_range(0, 3));
      bus.wr_data   = 8'($urandom);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.flush     = ($urandom_range(0, 5) == 0);
      bus.rd_addr_a = 2'($urandom_range(0, 3));
      bus.rd_addr_b = 2'($urandom_range(0, 3));
      bus.rd_addr_0 = ($urandom_range(0, 1) == 0) ? bus.rd_addr_a : 2'($urandom_range(0, 3));
      tick();
      exp = model_read(bus.rd_addr_a);
      checks++; if (bus.rd_data_a !== exp) begin errors++; $display("FAIL rand_a[%0d]: got %h want %h", n, bus.rd_data_a, exp); end
      exp = model_read(bus.rd_addr_b);
      checks++; if (bus.rd_data_b !== exp) begin errors++; $display("FAIL rand_b[%0d]: got %h want %h", n, bus.rd_data_b, exp); end
      exp = model_read(bus.rd_addr_0);
      checks++; if (bus.rd_data_0 !== exp) begin errors++; $display("FAIL rand_0[%0d]: got %h want %h", n, bus.rd_data_0, exp); end
      checks++; if (bus.wb_pending !== (m_pend.size() > 0)) begin errors++; $display("FAIL rand_pending[%0d]: got %b want %b", n, bus.wb_pending, m_pend.size() > 0); end
      checks++; if (bus.wr_dropped !== m_drop) begin errors++; $display("FAIL rand_dropped[%0d]: got %b want %b", n, bus.wr_dropped, m_drop); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.rd_addr_0 = '0;
    idle_inputs();
    m_drop = 1'b0;
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid();
    test_multi_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state in this block.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 rd_addr_a  input  2  mapped physical index for read port A (first source operand).
REQ-005 rd_addr_b  input  2  mapped physical index for read port B (second source operand).
REQ-006 rd_addr_0  input  2  mapped physical index for the implicit accumulator port.
REQ-007 wr_en  input  1  write request this cycle.
REQ-008 wr_addr  input  2  mapped physical destination index.
REQ-009 wr_data  input  8  write data.
REQ-010 stall  input  1  blocks capture of a new write request; does not block commit.
REQ-011 flush  input  1  squashes the pending write-back entry.
REQ-012 rd_data_a, rd_data_b, rd_data_0  output  8 each  read data for ports A, B and 0.
REQ-013 wb_pending  output  1  high while the write-back register holds an uncommitted entry.
REQ-014 wr_dropped  output  1  one-cycle pulse when a write request is lost to stall.

Function
REQ-015 Storage SHALL be 4 entries x 8 bits, indexed only by mapped physical indices; no remapping is done in this block.
REQ-016 Writes SHALL use a two-stage pipeline: capture into the write-back register (wb_valid, wb_addr, wb_data), then commit to the array.
REQ-017 Capture: on a rising edge with wr_en=1, stall=0 and reset=0, the block SHALL load wb_addr=wr_addr and wb_data=wr_data, and set wb_valid=1.
REQ-018 Commit: on a rising edge with wb_valid=1, flush=0 and reset=0, the block SHALL write wb_data into array[wb_addr], regardless of stall.
REQ-019 The block SHALL clear wb_valid after a commit unless a new capture occurs on the same edge; back-to-back captures sustain one write per cycle.
REQ-020 Reads SHALL be combinational. Each port SHALL return wb_data when wb_valid=1 and its address equals wb_addr (bypass); otherwise it SHALL return array[addr].
REQ-021 All three read ports SHALL bypass independently, including when two or three ports share the same address.
REQ-022 When flush=1 on an edge, the block SHALL discard the pending entry without committing it. A simultaneous wr_en=1 with stall=0 SHALL still be captured, giving wb_valid=1 with the new entry.
REQ-023 Back-to-back writes to the same address: the array SHALL receive the older value, then the newer one. Bypass SHALL always return the newest captured value.
REQ-024 wr_dropped SHALL be registered and go high for exactly the cycle after an edge with wr_en=1, stall=1 and reset=0.
REQ-025 wb_pending SHALL equal wb_valid.
REQ-026 Address wrap-around does not apply: all 2-bit indices 0..3 are valid, and no write SHALL be rejected for its address.

Reset
REQ-027 While reset=1 at a rising edge, all four array entries SHALL become 8'h00, wb_valid SHALL become 0, wb_addr and wb_data SHALL become 0, and wr_dropped SHALL become 0.
REQ-028 Reset SHALL take priority over capture, commit and flush. A pending entry present at a reset edge SHALL be discarded, not committed.
REQ-029 After reset, all read ports SHALL return 8'h00 and wb_pending SHALL be 0.

Verification
REQ-030 Basic write: after reset, wr_en=1, wr_addr=2, wr_data=8'h5A for one cycle, rd_addr_a=2 -> rd_data_a=8'h5A in the cycle after capture (bypass) and every cycle after it (array); wb_pending=1 for exactly one cycle.
REQ-031 Back-to-back same address: write 8'h11, then 8'h22, to address 1 on consecutive cycles, rd_addr_b=1 -> rd_data_b reads 8'h11, then 8'h22, then stays 8'h22; array[1] ends at 8'h22.
REQ-032 Flush: capture 8'h33 to address 3, assert flush on the next edge with wr_en=0 -> wb_pending=0 and rd_data_0 (addr 3) returns the old value 8'h00; a flush with a simultaneous write of 8'h44 to address 0 leaves wb_pending=1 and rd_data reads 8'h44 at address 0.
REQ-033 Stall: wr_en=1, stall=1, data 8'hAA to address 0 -> no capture, wr_dropped=1 for one cycle, address 0 still reads 8'h00; an already-pending entry still commits during the stall.
REQ-034 Reset mid-operation: capture 8'h77 to address 2 and assert reset on the next edge -> array[2]=8'h00, wb_pending=0, all read ports return 8'h00.
REQ-035 Multi-port bypass: rd_addr_a=rd_addr_b=rd_addr_0=1 with a pending 8'hC3 to address 1 -> all three ports return 8'hC3.
